// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the mul/div/HILO sequencer: FSM states, latched op kinds and HILO source selects.
// Op-kind codes deliberately equal the low bits of the matching HILO select.
package muldiv_seq_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  localparam logic [2:0] SEL_MULT  = 3'd0;
  localparam logic [2:0] SEL_MULTU = 3'd1;
  localparam logic [2:0] SEL_DIV   = 3'd2;
  localparam logic [2:0] SEL_DIVU  = 3'd3;
  localparam logic [2:0] SEL_RS    = 3'd4;
  localparam logic [2:0] SEL_ZERO  = 3'd5;

  function automatic logic [2:0] op_sel(op_e op);
    return {1'b0, op};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the main controller/datapath (master) and the mul/div sequencer (slave).
// Carries decoded ops and divider done flags in; start pulses, stall, HILO selects and write enables out.
interface muldiv_seq_if;

  logic       op_valid;
  logic       is_mult;
  logic       is_multu;
  logic       is_div;
  logic       is_divu;
  logic       is_mthi;
  logic       is_mtlo;
  logic       over_div;
  logic       over_divu;
  logic       start_div;
  logic       start_divu;
  logic       pc_no_add;
  logic       hiin;
  logic       loin;
  logic [2:0] M8;
  logic [2:0] M9;
  logic       md_busy;
  logic       md_err;

  modport master (
    output op_valid, is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, over_div, over_divu,
    input  start_div, start_divu, pc_no_add, hiin, loin, M8, M9, md_busy, md_err
  );

  modport slave (
    input  op_valid, is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, over_div, over_divu,
    output start_div, start_divu, pc_no_add, hiin, loin, M8, M9, md_busy, md_err
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences mult/div/mthi/mtlo onto HILO: mthi/mtlo write in 0 stall cycles, mult stalls MULT_LAT+1,
// div stalls 1+N until over_*; a DIV_TIMEOUT watchdog aborts a hung divider with an md_err pulse.
module muldiv_sequencer
  import muldiv_seq_pkg::*;
#(
  parameter int MULT_LAT    = 1,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic         clk_in,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_TIMEOUT - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       start_div, start_divu, pc_no_add, hiin, loin, md_busy, md_err;
  logic [2:0] m8, m9;
  logic       div_op, op_done;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_op  = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign op_done = ((op_q == OP_DIV)  && bus.over_div)  ||
                   ((op_q == OP_DIVU) && bus.over_divu) ||
                   (!div_op && (cnt_q == MULT_LAST));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    start_div  = 1'b0;
    start_divu = 1'b0;
    pc_no_add  = 1'b0;
    hiin       = 1'b0;
    loin       = 1'b0;
    m8         = SEL_ZERO;
    m9         = SEL_ZERO;
    md_err     = 1'b0;
    md_busy    = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          // Stalling ops share the same accept path; only the start pulse differs.
          if (bus.is_div || bus.is_divu || bus.is_mult || bus.is_multu) begin
            pc_no_add = 1'b1;
            state_d   = ST_WAIT;
            cnt_d     = '0;
            if (bus.is_div) begin
              start_div = 1'b1;
              op_d      = OP_DIV;
            end else if (bus.is_divu) begin
              start_divu = 1'b1;
              op_d       = OP_DIVU;
            end else if (bus.is_mult) begin
              op_d = OP_MULT;
            end else begin
              op_d = OP_MULTU;
            end
          end else if (bus.is_mthi) begin
            hiin = 1'b1;
            m8   = SEL_RS;
          end else if (bus.is_mtlo) begin
            loin = 1'b1;
            m9   = SEL_RS;
          end
        end
      end
      ST_WAIT: begin
        pc_no_add = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (op_done) begin
          state_d = ST_WRITE;
        end else if (div_op && (cnt_q == DIV_LAST)) begin
          // Abort lets the instruction retire without touching HILO.
          state_d   = ST_IDLE;
          md_err    = 1'b1;
          pc_no_add = 1'b0;
        end
      end
      ST_WRITE: begin
        hiin    = 1'b1;
        loin    = 1'b1;
        m8      = op_sel(op_q);
        m9      = op_sel(op_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!reset) begin
      start_div  = 1'b0;
      start_divu = 1'b0;
      pc_no_add  = 1'b0;
      hiin       = 1'b0;
      loin       = 1'b0;
      m8         = SEL_ZERO;
      m9         = SEL_ZERO;
      md_busy    = 1'b0;
      md_err     = 1'b0;
    end
  end

  assign bus.start_div  = start_div;
  assign bus.start_divu = start_divu;
  assign bus.pc_no_add  = pc_no_add;
  assign bus.hiin       = hiin;
  assign bus.loin       = loin;
  assign bus.M8         = m8;
  assign bus.M9         = m9;
  assign bus.md_busy    = md_busy;
  assign bus.md_err     = md_err;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: each op is predicted as a stall length plus a final write-or-abort
// cycle, derived from the op kind, MULT_LAT, DIV_TIMEOUT and the cycle at which the divider reports done.
module tb_muldiv_sequencer;

  localparam int MULT_LAT    = 1;
  localparam int DIV_TIMEOUT = 40;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  muldiv_seq_if bus();

  muldiv_sequencer #(
    .MULT_LAT   (MULT_LAT),
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  // Request mask bit order: 0 div, 1 divu, 2 mult, 3 multu, 4 mthi, 5 mtlo (also the priority order).
  function automatic logic [12:0] ev(bit sd, bit sdu, bit pc, bit hi, bit lo,
                                     logic [2:0] m8, logic [2:0] m9, bit busy, bit err);
    return {sd, sdu, pc, hi, lo, m8, m9, busy, err};
  endfunction

  function automatic logic [12:0] observed();
    return {bus.start_div, bus.start_divu, bus.pc_no_add, bus.hiin, bus.loin,
            bus.M8, bus.M9, bus.md_busy, bus.md_err};
  endfunction

  function automatic logic [2:0] result_sel(int op);
    case (op)
      0:       return 3'd2;
      1:       return 3'd3;
      2:       return 3'd0;
      default: return 3'd1;
    endcase
  endfunction

  task automatic drive(input logic [5:0] req, input logic vld, input logic od, input logic odu);
    bus.op_valid  = vld;
    bus.is_div    = req[0];
    bus.is_divu   = req[1];
    bus.is_mult   = req[2];
    bus.is_multu  = req[3];
    bus.is_mthi   = req[4];
    bus.is_mtlo   = req[5];
    bus.over_div  = od;
    bus.over_divu = odu;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one request from IDLE and follow it to completion; d = cycle (after accept) at which the
  // matching divider reports done, 0 = never.
  task automatic run_op(input logic [5:0] req, input int d, input string nm);
    int          op;
    int          s;
    bit          err;
    logic        od, odu;
    logic [12:0] want, got;
    op = -1;
    for (int i = 0; i < 6; i++) if (req[i] && op < 0) op = i;
    if (op < 0 || op >= 4) begin
      drive(req, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk_in);
      if (op == 4)      want = ev(0, 0, 0, 1, 0, 3'd4, 3'd5, 0, 0);
      else if (op == 5) want = ev(0, 0, 0, 0, 1, 3'd5, 3'd4, 0, 0);
      else              want = ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0);
      got = observed();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s single-cycle got=%h want=%h", nm, got, want);
      end
      step();
      drive(6'd0, 1'b0, 1'b0, 1'b0);
      return;
    end
    err = (op < 2) && (d <= 0 || d > DIV_TIMEOUT);
    if (op >= 2)  s = MULT_LAT + 1;
    else if (err) s = DIV_TIMEOUT;
    else          s = d + 1;
    for (int k = 0; k <= s; k++) begin
      od  = 1'($urandom_range(0, 1));
      odu = 1'($urandom_range(0, 1));
      if (op == 0 && k > 0) od  = (d > 0) && (k >= d);
      if (op == 1 && k > 0) odu = (d > 0) && (k >= d);
      drive(req, 1'b1, od, odu);
      @(negedge clk_in);
      want = ev(k == 0 && op == 0, k == 0 && op == 1, k < s,
                k == s && !err, k == s && !err,
                (k == s && !err) ? result_sel(op) : 3'd5,
                (k == s && !err) ? result_sel(op) : 3'd5,
                k >= 1, k == s && err);
      got = observed();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s op=%0d d=%0d k=%0d got=%h want=%h", nm, op, d, k, got, want);
      end
      step();
    end
    drive(6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(6'b000001, 1'b1, 1'b1, 1'b1);
      @(negedge clk_in);
      got = observed();
      checks++;
      if (got !== ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0)) begin
        failures++;
        $display("FAIL reset_hold k=%0d got=%h want=%h", k, got, ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0));
      end
      step();
    end
    reset = 1'b1;
    run_op(6'b000001, 3, "reset_release_div");
  endtask

  task automatic test_mthi_mtlo();
    logic [12:0] got;
    run_op(6'b010000, 0, "mthi");
    run_op(6'b010000, 0, "mthi_again");
    run_op(6'b100000, 0, "mtlo");
    run_op(6'b110000, 0, "mthi_over_mtlo");
    drive(6'b010000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    got = observed();
    checks++;
    if (got !== ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0)) begin
      failures++;
      $display("FAIL mthi_not_valid got=%h want=%h", got, ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0));
    end
    step();
    drive(6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div_multu();
    run_op(6'b000001, 34, "div_34");
    run_op(6'b000010, 5, "divu_5");
    run_op(6'b001000, 0, "multu");
    run_op(6'b000100, 0, "mult");
    run_op(6'b000001, DIV_TIMEOUT, "div_done_at_limit");
  endtask

  task automatic test_timeout();
    logic [12:0] got;
    run_op(6'b000001, 0, "div_timeout");
    @(negedge clk_in);
    got = observed();
    checks++;
    if (got !== ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0)) begin
      failures++;
      $display("FAIL after_timeout_idle got=%h want=%h", got, ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0));
    end
    step();
    run_op(6'b000010, DIV_TIMEOUT + 3, "divu_late_timeout");
  endtask

  task automatic test_priority_and_midreset();
    logic [12:0] got, want;
    run_op(6'b010101, 2, "prio_div_mult_mthi");
    run_op(6'b011110, 4, "prio_divu");
    run_op(6'b111100, 0, "prio_mult");
    for (int k = 0; k < 8; k++) begin
      if (k == 4) reset = 1'b0;
      if (k == 5) reset = 1'b1;
      if (k < 5) drive(6'b000001, 1'b1, 1'b0, 1'b0);
      else       drive(6'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk_in);
      if (k == 0)      want = ev(1, 0, 1, 0, 0, 3'd5, 3'd5, 0, 0);
      else if (k < 4)  want = ev(0, 0, 1, 0, 0, 3'd5, 3'd5, 1, 0);
      else             want = ev(0, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0);
      got = observed();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL midwait_reset k=%0d got=%h want=%h", k, got, want);
      end
      step();
    end
    drive(6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] req;
    for (int n = 0; n < 25; n++) begin
      req = 6'($urandom_range(1, 63));
      run_op(req, int'($urandom_range(1, DIV_TIMEOUT + 4)), "random_b2b");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(6'd0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_mthi_mtlo();
    test_div_multu();
    test_timeout();
    test_priority_and_midreset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
